// File: rtl/gray_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : gray_rx_if
// Brief    : Sample/status bundle between a Gray-code source and gray_rx.
//            Carries Err_count only when GRAY_RX_ERRCNT_EN is defined.
// Revision : 1.0
// ============================================================================
interface gray_rx_if #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 8
);
   logic             In_valid;
   logic [WIDTH-1:0] In_gray;
   logic             Resync;
   logic [WIDTH-1:0] Bin_out;
   logic             Out_valid;
   logic             Wrap;
   logic [CNT_W-1:0] Wrap_count;
   logic             Err;
   logic             Err_sticky;
   logic [1:0]       State;
`ifdef GRAY_RX_ERRCNT_EN
   logic [CNT_W-1:0] Err_count;

   modport master (
      output In_valid, In_gray, Resync,
      input  Bin_out, Out_valid, Wrap, Wrap_count, Err, Err_sticky, State, Err_count
   );
   modport slave (
      input  In_valid, In_gray, Resync,
      output Bin_out, Out_valid, Wrap, Wrap_count, Err, Err_sticky, State, Err_count
   );
`else
   modport master (
      output In_valid, In_gray, Resync,
      input  Bin_out, Out_valid, Wrap, Wrap_count, Err, Err_sticky, State
   );
   modport slave (
      input  In_valid, In_gray, Resync,
      output Bin_out, Out_valid, Wrap, Wrap_count, Err, Err_sticky, State
   );
`endif
endinterface
`default_nettype wire

// File: rtl/gray_rx.sv
`default_nettype none
// ============================================================================
// Module   : gray_rx
// Brief    : Gray-code receiver: decode, successor check, wrap counting.
//            Define GRAY_RX_ERRCNT_EN to add the saturating Err_count output.
// Revision : 1.0
// ============================================================================
module gray_rx #(
   parameter int WIDTH      = 3,
   parameter int CNT_W      = 8,
   parameter int ALLOW_HOLD = 1
) (
   input  wire logic Clk,
   input  wire logic Reset,
   gray_rx_if.slave  bus
);
   localparam logic [1:0]       c_SYNC    = 2'b00;
   localparam logic [1:0]       c_TRACK   = 2'b01;
   localparam logic [1:0]       c_LOCKED  = 2'b10;
   localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_MAX     = {WIDTH{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] r_ref;
   logic [WIDTH-1:0] w_bin;
   logic             r_out_valid;
   logic             r_wrap;
   logic             r_err;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_wrap_cnt;
   logic             w_check;
   logic             w_step;
   logic             w_hold;
   logic             w_legal;
   logic             w_wrap_tr;
   logic             w_err_nxt;
   logic             w_wrap_nxt;

   // Each binary bit is the XOR of all Gray bits at and above it.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign w_bin[gi] = ^bus.In_gray[WIDTH-1:gi];
   end

   assign w_step    = (w_bin == r_ref + c_ONE);
   assign w_hold    = (ALLOW_HOLD != 0) && (w_bin == r_ref);
   assign w_legal   = w_step || w_hold;
   assign w_wrap_tr = (r_ref == c_MAX) && (w_bin == '0);

   always_ff @(posedge Clk) begin
      if (Reset) r_state <= c_SYNC;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (bus.Resync) begin
         w_state_nxt = bus.In_valid ? c_TRACK : c_SYNC;
      end else begin
         case (r_state)
            c_SYNC:   if (bus.In_valid) w_state_nxt = c_TRACK;
            c_TRACK:  if (bus.In_valid && !w_legal) w_state_nxt = c_LOCKED;
            c_LOCKED: w_state_nxt = c_LOCKED;
            default:  w_state_nxt = c_SYNC;
         endcase
      end
   end

   // Only a non-resync sample taken while tracking is checked.
   always_comb begin
      w_check    = bus.In_valid && !bus.Resync && (r_state == c_TRACK);
      w_err_nxt  = w_check && !w_legal;
      w_wrap_nxt = w_check && w_wrap_tr;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_ref        <= '0;
         r_out_valid  <= 1'b0;
         r_wrap       <= 1'b0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
         r_wrap_cnt   <= '0;
      end else begin
         r_out_valid <= bus.In_valid;
         r_wrap      <= w_wrap_nxt;
         r_err       <= w_err_nxt;
         if (bus.In_valid) r_ref <= w_bin;
         if (w_err_nxt) r_err_sticky <= 1'b1;
         if (w_wrap_nxt && (r_wrap_cnt != c_CNT_MAX)) r_wrap_cnt <= r_wrap_cnt + c_CNT_ONE;
      end
   end

   assign bus.Bin_out    = r_ref;
   assign bus.Out_valid  = r_out_valid;
   assign bus.Wrap       = r_wrap;
   assign bus.Wrap_count = r_wrap_cnt;
   assign bus.Err        = r_err;
   assign bus.Err_sticky = r_err_sticky;
   assign bus.State      = r_state;

`ifdef GRAY_RX_ERRCNT_EN
   logic [CNT_W-1:0] r_err_cnt;

   always_ff @(posedge Clk) begin
      if (Reset)                                     r_err_cnt <= '0;
      else if (w_err_nxt && (r_err_cnt != c_CNT_MAX)) r_err_cnt <= r_err_cnt + c_CNT_ONE;
   end

   assign bus.Err_count = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_rx
// Brief    : Directed self-checking bench for gray_rx (hold and no-hold builds).
// Revision : 1.0
// ============================================================================
module tb_gray_rx;
   logic Clk = 1'b0;
   logic Reset;
   int   checks   = 0;
   int   failures = 0;

   always #5 Clk = ~Clk;

   gray_rx_if #(.WIDTH(3), .CNT_W(8)) bus ();
   gray_rx_if #(.WIDTH(3), .CNT_W(8)) nbus ();

   gray_rx #(.WIDTH(3), .CNT_W(8), .ALLOW_HOLD(1)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   gray_rx #(.WIDTH(3), .CNT_W(8), .ALLOW_HOLD(0)) dut_nh (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (nbus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, then sample 1 time unit after the edge.
   task automatic step(input logic v, input logic [2:0] g, input logic rs = 1'b0,
                       input logic nv = 1'b0, input logic [2:0] ng = 3'b000);
      @(negedge Clk);
      bus.In_valid  = v;
      bus.In_gray   = g;
      bus.Resync    = rs;
      nbus.In_valid = nv;
      nbus.In_gray  = ng;
      nbus.Resync   = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset        = 1'b1;
      bus.In_valid = 1'b1;
      bus.In_gray  = 3'b111;
      bus.Resync   = 1'b0;
      nbus.In_valid = 1'b0;
      @(posedge Clk);
      #1;
      @(negedge Clk);
      Reset        = 1'b0;
      bus.In_valid = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic [2:0] b, input logic ov,
                          input logic w, input logic e);
      chk({tag, ".bin"},  bus.Bin_out,   b);
      chk({tag, ".ov"},   bus.Out_valid, ov);
      chk({tag, ".wrap"}, bus.Wrap,      w);
      chk({tag, ".err"},  bus.Err,       e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] gseq [8];
      gseq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
      Reset = 1'b0;
      bus.In_valid = 1'b0; bus.In_gray = '0; bus.Resync = 1'b0;
      nbus.In_valid = 1'b0; nbus.In_gray = '0; nbus.Resync = 1'b0;

      // Reset state, with In_valid high to show Reset priority
      do_reset();
      chk_out("rst", 3'd0, 1'b0, 1'b0, 1'b0);
      chk("rst.wcnt",   bus.Wrap_count, 8'd0);
      chk("rst.sticky", bus.Err_sticky, 1'b0);
      chk("rst.state",  bus.State,      2'b00);
      chk("rst.nh_state", nbus.State,   2'b00);

      // 1: full count 0..7 then wrap to 0
      for (int i = 0; i < 8; i++) begin
         step(1'b1, gseq[i]);
         chk_out($sformatf("t1[%0d]", i), 3'(i), 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, 3'b000);
      chk_out("t1.wrap", 3'd0, 1'b1, 1'b1, 1'b0);
      chk("t1.wcnt",  bus.Wrap_count, 8'd1);
      chk("t1.state", bus.State,      2'b01);
      step(1'b0, 3'b000);
      chk("t1.idle_ov",   bus.Out_valid, 1'b0);
      chk("t1.idle_wrap", bus.Wrap,      1'b0);

      // 2: hold, step, then an illegal jump 1 -> 3
      step(1'b1, 3'b000);
      chk_out("t2.hold", 3'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 3'b001);
      chk_out("t2.one", 3'd1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 3'b010);
      chk_out("t2.bad", 3'd3, 1'b1, 1'b0, 1'b1);
      chk("t2.sticky", bus.Err_sticky, 1'b1);
      chk("t2.state",  bus.State,      2'b10);
      step(1'b1, 3'b110);
      chk_out("t2.locked", 3'd4, 1'b1, 1'b0, 1'b0);
      chk("t2.lstate", bus.State, 2'b10);

      // 3: Resync out of LOCKED
      step(1'b1, 3'b111, 1'b1);
      chk_out("t3.rs", 3'd5, 1'b1, 1'b0, 1'b0);
      chk("t3.state",  bus.State,      2'b01);
      chk("t3.sticky", bus.Err_sticky, 1'b1);
      step(1'b1, 3'b101);
      chk_out("t3.next", 3'd6, 1'b1, 1'b0, 1'b0);
      step(1'b0, 3'b000, 1'b1);
      chk("t3.sync",  bus.State,     2'b00);
      chk("t3.sync_ov", bus.Out_valid, 1'b0);
      step(1'b1, 3'b000);
      chk_out("t3.unchk", 3'd0, 1'b1, 1'b0, 1'b0);
      chk("t3.track", bus.State, 2'b01);
      chk("t3.wcnt",  bus.Wrap_count, 8'd1);

      // 4: repeated code, hold allowed vs. not allowed
      step(1'b0, 3'b000, 1'b1);
      step(1'b1, 3'b011, 1'b0, 1'b1, 3'b011);
      chk_out("t4.a", 3'd2, 1'b1, 1'b0, 1'b0);
      chk("t4.nh_a_err", nbus.Err, 1'b0);
      chk("t4.nh_a_bin", nbus.Bin_out, 3'd2);
      step(1'b1, 3'b011, 1'b0, 1'b1, 3'b011);
      chk_out("t4.b", 3'd2, 1'b1, 1'b0, 1'b0);
      chk("t4.state",     bus.State,  2'b01);
      chk("t4.nh_b_err",  nbus.Err,   1'b1);
      chk("t4.nh_state",  nbus.State, 2'b10);

      // 5: many wraps (Wrap_count saturation), then Reset mid-sequence
      do_reset();
      step(1'b1, 3'b000);
      for (int w = 0; w < 260; w++) begin
         for (int i = 1; i < 8; i++) step(1'b1, gseq[i]);
         step(1'b1, 3'b000);
         if (w == 7) chk("t5.wcnt8", bus.Wrap_count, 8'd8);
      end
      chk("t5.wsat",   bus.Wrap_count, 8'd255);
      chk("t5.werr",   bus.Err_sticky, 1'b0);
      step(1'b1, 3'b001);
      step(1'b1, 3'b011);
      step(1'b1, 3'b010);
      step(1'b1, 3'b110);
      chk("t5.pre_bin", bus.Bin_out, 3'd4);
      do_reset();
      chk_out("t5.rst", 3'd0, 1'b0, 1'b0, 1'b0);
      chk("t5.rst_wcnt",  bus.Wrap_count, 8'd0);
      chk("t5.rst_state", bus.State,      2'b00);
      step(1'b1, 3'b111);
      chk_out("t5.first", 3'd5, 1'b1, 1'b0, 1'b0);
      chk("t5.state", bus.State,      2'b01);
      chk("t5.wcnt",  bus.Wrap_count, 8'd0);

`ifdef GRAY_RX_ERRCNT_EN
      // 6: three illegal transitions separated by Resync
      chk("t6.ecnt0", bus.Err_count, 8'd0);
      step(1'b1, 3'b000);
      chk("t6.e1", bus.Err, 1'b1);
      step(1'b1, 3'b000, 1'b1);
      step(1'b1, 3'b011);
      chk("t6.e2", bus.Err, 1'b1);
      step(1'b1, 3'b000, 1'b1);
      step(1'b1, 3'b100);
      chk("t6.e3", bus.Err, 1'b1);
      chk("t6.ecnt3", bus.Err_count, 8'd3);
      step(1'b0, 3'b000, 1'b1);
      chk("t6.rs_keep", bus.Err_count, 8'd3);
      do_reset();
      chk("t6.rst_clr", bus.Err_count, 8'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/gray_rx.md
Name: gray_rx

Overview:
- Receiving end of the Gray-code counter link. Samples a WIDTH-bit Gray code whenever In_valid is high and converts it to binary.
- Checks that every new code is the legal successor of the previous one, and counts wrap-arounds (max -> 0), the receive-side counterpart of the counter's overflow.
- Sits downstream of the gray counter, typically across a clock-domain or pipeline boundary. Gives the consumer a binary count plus integrity status.

Parameters:
- WIDTH, 3, code width in bits (>=2).
- CNT_W, 8, width of Wrap_count.
- ALLOW_HOLD, 1, 1 = a repeated identical code is legal; 0 = a repeat is an error.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  reset Reset, synchronous, active-high; clock Clk.
- In_valid  input  1  In_gray is valid this cycle.
- In_gray  input  WIDTH  incoming Gray code.
- Resync  input  1  abandon the current reference; next sample becomes the new reference.
- Bin_out  output  WIDTH  binary value of the last accepted sample.
- Out_valid  output  1  one-cycle pulse, Bin_out updated.
- Wrap  output  1  one-cycle pulse on a legal max->0 transition.
- Wrap_count  output  CNT_W  number of wraps, saturating at all-ones.
- Err  output  1  one-cycle pulse on an illegal transition.
- Err_sticky  output  1  set by any Err, cleared only by Reset.
- State  output  2  00 SYNC, 01 TRACK, 10 LOCKED.

Behaviour:
- Reset values: Bin_out=0, Out_valid=0, Wrap=0, Wrap_count=0, Err=0, Err_sticky=0, State=SYNC. The internal reference register is cleared to 0.
- Reset has priority over all inputs. Reset mid-stream discards the reference, and the next sample is unchecked.
- Decode is combinational:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] ^ g[i]
- Latency is 1 cycle. When In_valid is sampled at edge k, Bin_out/Out_valid/Wrap/Err are valid after edge k. Out_valid, Wrap and Err are low in every cycle without an accepted sample.
- Every valid sample is decoded and output in all states, and becomes the new reference.
- Let p = reference and n = decoded sample; arithmetic is mod 2^WIDTH.
- SYNC:
  - Valid sample: no check, reference = n, State -> TRACK.
  - Otherwise: stay in SYNC.
- TRACK, valid sample:
  - n == p+1 with p != max: legal.
  - p == max and n == 0: legal. Wrap=1 and Wrap_count increments, holding at 2^CNT_W-1 once reached.
  - n == p: legal if ALLOW_HOLD=1. If ALLOW_HOLD=0 it is treated as illegal.
  - Any other value is illegal: Err=1, Err_sticky=1, State -> LOCKED.
- LOCKED:
  - Samples are decoded and output.
  - No checking, no Wrap, no counting.
  - Leaves only via Resync or Reset.
- Resync, in any state:
  - Resync with In_valid: the sample is output unchecked, becomes the reference, State -> TRACK.
  - Resync without In_valid: State -> SYNC.
  - Resync does not clear Err_sticky or Wrap_count.
- A single illegal sample produces exactly one Err pulse. Later samples while in LOCKED produce none.

Optional Feature:
- Macro GRAY_RX_ERRCNT_EN.
- Defined:
  - Adds output Err_count [CNT_W], reset value 0.
  - Increments on every Err pulse and saturates at all-ones.
  - Cleared only by Reset; Resync does not clear it.
- Undefined: the port is absent and no counter logic is generated. All other behaviour is identical.

Test Plan (WIDTH=3, CNT_W=8, ALLOW_HOLD=1 unless stated):
1. After Reset, feed 000,001,011,010,110,111,101,100,000 on consecutive cycles -> Bin_out 0,1,2,3,4,5,6,7,0, each with Out_valid. Wrap pulses only with the final 0. Wrap_count=1, Err never, State=TRACK.
2. Feed 000,001 then 010 -> Bin_out=3, Err pulse, Err_sticky=1, State=LOCKED. Then feed 110 -> Bin_out=4, no Err, no Wrap.
3. From LOCKED, Resync=1 with In_valid and In_gray=111 -> Bin_out=5, State=TRACK, Err_sticky stays 1. Next 101 -> Bin_out=6, no Err.
4. Feed 011,011 -> no Err with ALLOW_HOLD=1. Same stimulus with ALLOW_HOLD=0 -> Err on the second sample, State=LOCKED.
5. Run 8 full wraps, then assert Reset mid-sequence (after code 110), then feed 111 -> after Reset all outputs are 0 and State=SYNC. The 111 sample is unchecked: Bin_out=5, no Err, State=TRACK, Wrap_count=0.
6. With GRAY_RX_ERRCNT_EN defined, cause 3 illegal transitions, each separated by a Resync -> Err_count=3. Resync leaves it at 3, and Reset clears it to 0.
